ev_drive_pwm_ctrl: RTL and testbench

EV_DRIVE_PWM_CTRL -- requirements
Module: ev_drive_pwm_ctrl

---
 rtl/ev_drive_pkg.sv | 19 +
 rtl/ev_ramp_pwm_ch.sv | 56 +++++
 rtl/ev_drive_pwm_ctrl.sv | 138 +++++++++++++
 tb/tb_ev_drive_pwm_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ev_drive_pkg.sv
// Shared types and default thresholds for the EV drive PWM controller.
package ev_drive_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_DERATE = 2'd2
  } drive_state_e;

  localparam int T_HI_DEF      = 110;
  localparam int T_LO_DEF      = 100;
  localparam int RAMP_STEP_DEF = 4;

  // Channel-select width; a single channel still gets a 1-bit selector.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ev_ramp_pwm_ch.sv
// One motor channel: speed ramp toward target, period-aligned duty shadow, PWM compare.
// Speed moves one step per tick; pwm_out is registered one cycle behind the counter.
module ev_ramp_pwm_ch import ev_drive_pkg::*; #(
  parameter int DW        = 8,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_tick,
  input  logic [DW-1:0] i_target,
  input  logic [DW-1:0] i_pwm_cnt,
  output logic [DW-1:0] o_speed,
  output logic          o_pwm,
  output logic          o_at_target
);

  localparam logic [DW:0]   STEP    = (DW+1)'(RAMP_STEP);
  localparam logic [DW-1:0] CNT_MAX = '1;

  logic [DW-1:0] r_speed;
  logic [DW-1:0] r_shadow;
  logic          r_pwm;
  logic [DW:0]   w_spd_x;
  logic [DW:0]   w_tgt_x;
  logic [DW-1:0] w_next;

  // One extra bit keeps the distance compare and step free of wrap.
  always_comb begin
    w_spd_x = {1'b0, r_speed};
    w_tgt_x = {1'b0, i_target};
    w_next  = r_speed;
    if (w_tgt_x > w_spd_x) begin
      w_next = ((w_tgt_x - w_spd_x) > STEP) ? DW'(w_spd_x + STEP) : i_target;
    end else if (w_tgt_x < w_spd_x) begin
      w_next = ((w_spd_x - w_tgt_x) > STEP) ? DW'(w_spd_x - STEP) : i_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_speed  <= '0;
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_tick) r_speed <= w_next;
      if (i_pwm_cnt == CNT_MAX) r_shadow <= r_speed;
      r_pwm <= (i_pwm_cnt < r_shadow);
    end
  end

  assign o_speed     = r_speed;
  assign o_pwm       = r_pwm;
  assign o_at_target = (r_speed == i_target);

endmodule

// File: rtl/ev_drive_pwm_ctrl.sv
// Multi-channel EV drive controller: power FSM, thermal derate, command decode, ramped PWM.
// Commands land one cycle after the handshake; cmd_ready is high only while powered.
module ev_drive_pwm_ctrl import ev_drive_pkg::*; #(
  parameter int N_CH      = 2,
  parameter int DW        = 8,
  parameter int DIV_W     = 8,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int TEMP_W    = 7,
  parameter int T_HI      = T_HI_DEF,
  parameter int T_LO      = T_LO_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ch_idx_w(N_CH)-1:0] cmd_ch,
  input  logic [DW-1:0]             cmd_accel,
  input  logic [DW-1:0]             cmd_brake,
  input  logic [DIV_W-1:0]          prescale,
  input  logic [TEMP_W-1:0]         temp,
  output logic [N_CH-1:0]           pwm_out,
  output logic [N_CH*DW-1:0]        speed_out,
  output logic [N_CH-1:0]           at_target,
  output logic                      overheat,
  output logic                      cmd_err,
  output logic [1:0]                state_out
);

  localparam int                CH_W   = ch_idx_w(N_CH);
  localparam logic [CH_W:0]     N_CH_V = (CH_W+1)'(N_CH);
  localparam logic [TEMP_W-1:0] T_HI_V = TEMP_W'(T_HI);
  localparam logic [TEMP_W-1:0] T_LO_V = TEMP_W'(T_LO);

  drive_state_e  r_state;
  drive_state_e  w_state_nxt;
  logic          r_overheat;
  logic          r_cmd_err;
  logic [DIV_W-1:0] r_div;
  logic [DW-1:0] r_pcnt;
  logic [DW-1:0] r_target [N_CH];
  logic          w_xfer;
  logic          w_ch_ok;
  logic          w_tick;
  logic          w_clr;
  logic [DW-1:0] w_diff;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_OFF;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:    if (enable) w_state_nxt = r_overheat ? ST_DERATE : ST_RUN;
      ST_RUN:    if (r_overheat) w_state_nxt = ST_DERATE;
      ST_DERATE: if (!r_overheat) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_OFF;
    endcase
    if (!enable) w_state_nxt = ST_OFF;
  end

  always_comb begin
    cmd_ready = (r_state == ST_RUN) || (r_state == ST_DERATE);
    state_out = r_state;
  end

  // Hysteresis band between the thresholds keeps the previous flag.
  always_ff @(posedge clk) begin
    if (!rst_n)                r_overheat <= 1'b0;
    else if (temp >= T_HI_V)   r_overheat <= 1'b1;
    else if (temp <= T_LO_V)   r_overheat <= 1'b0;
  end

  assign w_xfer  = cmd_valid && cmd_ready;
  assign w_ch_ok = ({1'b0, cmd_ch} < N_CH_V);
  assign w_diff  = (cmd_accel > cmd_brake) ? (cmd_accel - cmd_brake) : '0;
  assign w_clr   = !enable;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      for (int k = 0; k < N_CH; k++) r_target[k] <= '0;
    end else if (w_xfer) begin
      for (int k = 0; k < N_CH; k++) begin
        if (CH_W'(k) == cmd_ch) r_target[k] <= w_diff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_cmd_err <= 1'b0;
    else        r_cmd_err <= w_xfer && !w_ch_ok;
  end

  assign w_tick = (r_state != ST_OFF) && (r_div >= prescale);

  always_ff @(posedge clk) begin
    if (!rst_n || r_state == ST_OFF) begin
      r_div  <= '0;
      r_pcnt <= '0;
    end else begin
      r_div  <= w_tick ? '0 : r_div + 1'b1;
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DW-1:0] w_eff;

    always_comb begin
      case (r_state)
        ST_RUN:    w_eff = r_target[g];
        ST_DERATE: w_eff = r_target[g] >> 1;
        default:   w_eff = '0;
      endcase
    end

    ev_ramp_pwm_ch #(
      .DW        (DW),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (w_clr),
      .i_tick      (w_tick),
      .i_target    (w_eff),
      .i_pwm_cnt   (r_pcnt),
      .o_speed     (speed_out[g*DW +: DW]),
      .o_pwm       (pwm_out[g]),
      .o_at_target (at_target[g])
    );
  end

  assign overheat = r_overheat;
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_ev_drive_pwm_ctrl.sv
// Self-checking bench for ev_drive_pwm_ctrl: command table with a ramp scoreboard plus
// hand-written sequences for duty, derate, disable, bad channel, prescale and reset.
module tb_ev_drive_pwm_ctrl;

  localparam int N_CH = 3;
  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int STEP = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CW-1:0]        cmd_ch;
  logic [DW-1:0]        cmd_accel;
  logic [DW-1:0]        cmd_brake;
  logic [7:0]           prescale;
  logic [6:0]           temp;
  logic [N_CH-1:0]      pwm_out;
  logic [N_CH*DW-1:0]   speed_out;
  logic [N_CH-1:0]      at_target;
  logic                 overheat;
  logic                 cmd_err;
  logic [1:0]           state_out;

  ev_drive_pwm_ctrl #(
    .N_CH(N_CH), .DW(DW), .DIV_W(8), .RAMP_STEP(STEP), .TEMP_W(7), .T_HI(110), .T_LO(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_accel(cmd_accel), .cmd_brake(cmd_brake), .prescale(prescale),
    .temp(temp), .pwm_out(pwm_out), .speed_out(speed_out), .at_target(at_target),
    .overheat(overheat), .cmd_err(cmd_err), .state_out(state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2 ms, required to finish");
    $fatal(1);
  end

  typedef struct {
    int ch;
    int accel;
    int brake;
    int exp_spd;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int m_tgt [N_CH];
  int m_spd [N_CH];
  bit m_derate = 1'b0;
  int sb_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int spd(input int ch);
    return int'(speed_out[ch*DW +: DW]);
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_cmd(input int ch, input int a, input int b);
    check("cmd_ready before cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ch    = CW'(ch);
    cmd_accel = DW'(a);
    cmd_brake = DW'(b);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (ch < N_CH) m_tgt[ch] = (a > b) ? a - b : 0;
  endtask

  task automatic run_ramp(input int ch, input string nm);
    int eff, s, last, cur;
    bit done;
    eff = m_derate ? (m_tgt[ch] >> 1) : m_tgt[ch];
    s = m_spd[ch];
    while (s != eff) begin
      if (eff > s) s = (eff - s > STEP) ? s + STEP : eff;
      else         s = (s - eff > STEP) ? s - STEP : eff;
      sb_q.push_back(s);
    end
    last = spd(ch);
    done = 1'b0;
    for (int c = 0; c < 800 && !done; c++) begin
      @(negedge clk);
      cur = spd(ch);
      if (cur != last) begin
        if (sb_q.size() == 0) check({nm, " extra step"}, cur, last);
        else                  check(nm, cur, sb_q.pop_front());
        last = cur;
      end
      if (sb_q.size() == 0 && at_target[ch]) done = 1'b1;
    end
    check({nm, " steps left"}, sb_q.size(), 0);
    sb_q.delete();
    check({nm, " at_target"}, at_target[ch], 1);
    m_spd[ch] = eff;
  endtask

  vec_t vecs [7];
  int   hi [N_CH];
  int   last, gap;
  bit   seen;

  initial begin
    vecs[0] = '{0, 100, 20, 80};
    vecs[1] = '{0, 30, 50, 0};
    vecs[2] = '{1, 200, 0, 200};
    vecs[3] = '{2, 255, 1, 254};
    vecs[4] = '{1, 50, 50, 0};
    vecs[5] = '{2, 7, 0, 7};
    vecs[6] = '{0, 100, 20, 80};
    for (int k = 0; k < N_CH; k++) begin
      m_tgt[k] = 0;
      m_spd[k] = 0;
    end

    rst_n = 1'b0; enable = 1'b0; cmd_valid = 1'b1; cmd_ch = '0;
    cmd_accel = 8'd100; cmd_brake = 8'd20; prescale = 8'd0; temp = 7'd20;
    repeat (3) @(negedge clk);
    check("reset speed_out", speed_out, 0);
    check("reset pwm_out", pwm_out, 0);
    check("reset cmd_ready", cmd_ready, 0);
    check("reset state", state_out, 0);
    check("reset cmd_err", cmd_err, 0);
    check("reset overheat", overheat, 0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("disabled state", state_out, 0);
    check("disabled cmd_ready", cmd_ready, 0);
    check("disabled no transfer", speed_out, 0);
    cmd_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("enable state RUN", state_out, 1);
    check("enable cmd_ready", cmd_ready, 1);

    foreach (vecs[i]) begin
      send_cmd(vecs[i].ch, vecs[i].accel, vecs[i].brake);
      run_ramp(vecs[i].ch, $sformatf("vec%0d ramp", i));
      check($sformatf("vec%0d final speed", i), spd(vecs[i].ch), vecs[i].exp_spd);
    end

    repeat (512) @(negedge clk);
    for (int k = 0; k < N_CH; k++) hi[k] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int k = 0; k < N_CH; k++) if (pwm_out[k]) hi[k]++;
    end
    for (int k = 0; k < N_CH; k++) check($sformatf("duty ch%0d", k), hi[k], m_spd[k]);

    send_cmd(2, 0, 9);
    run_ramp(2, "ch2 to zero");

    temp = 7'd110;
    @(negedge clk);
    check("overheat set", overheat, 1);
    check("still RUN one cycle", state_out, 1);
    @(negedge clk);
    check("DERATE entered", state_out, 2);
    check("derate entry no step", spd(0), 80);
    m_derate = 1'b1;
    run_ramp(0, "derate ramp");
    temp = 7'd105;
    repeat (5) @(negedge clk);
    check("hysteresis overheat", overheat, 1);
    check("hysteresis state", state_out, 2);
    temp = 7'd100;
    @(negedge clk);
    check("overheat clear", overheat, 0);
    @(negedge clk);
    check("RUN resumed", state_out, 1);
    check("derate exit no step", spd(0), 40);
    m_derate = 1'b0;
    run_ramp(0, "recover ramp");

    send_cmd(0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (spd(0) == 44) seen = 1'b1;
    end
    check("reached speed 44", seen, 1);
    enable = 1'b0;
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_accel = 8'd200; cmd_brake = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("disable state OFF", state_out, 0);
    check("disable speed_out", speed_out, 0);
    check("disable pwm_out", pwm_out, 0);
    check("disable cmd_ready", cmd_ready, 0);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("re-enable state", state_out, 1);
    check("dropped cmd speed", spd(0), 0);
    check("dropped cmd at_target", at_target[0], 1);
    for (int k = 0; k < N_CH; k++) begin
      m_tgt[k] = 0;
      m_spd[k] = 0;
    end

    send_cmd(1, 100, 0);
    run_ramp(1, "ch1 to 100");
    send_cmd(3, 90, 0);
    check("bad ch cmd_err pulse", cmd_err, 1);
    @(negedge clk);
    check("bad ch cmd_err clears", cmd_err, 0);
    repeat (30) @(negedge clk);
    check("bad ch speeds kept", speed_out, {8'd0, 8'd100, 8'd0});
    check("bad ch at_target", at_target, 3'b111);

    prescale = 8'd3;
    send_cmd(1, 0, 0);
    last = spd(1);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (spd(1) != last) seen = 1'b1;
    end
    check("prescale first step", spd(1), 96);
    last = spd(1);
    gap = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      gap++;
      if (spd(1) != last) seen = 1'b1;
    end
    check("prescale tick gap", gap, 4);
    check("prescale second step", spd(1), 92);
    prescale = 8'd0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (at_target[1]) seen = 1'b1;
    end
    check("prescale ramp done", spd(1), 0);

    temp = 7'd120;
    repeat (3) @(negedge clk);
    check("hot overheat", overheat, 1);
    check("hot DERATE", state_out, 2);
    send_cmd(0, 200, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midramp reset speed", speed_out, 0);
    check("midramp reset pwm", pwm_out, 0);
    check("midramp reset state", state_out, 0);
    check("midramp reset overheat", overheat, 0);
    check("midramp reset cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    temp = 7'd20;
    repeat (5) @(negedge clk);
    check("post reset state", state_out, 1);
    check("post reset target cleared", spd(0), 0);
    check("post reset at_target", at_target, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
